pong_match_controller: RTL and testbench

//  Match-level sequencer for the two-player pong datapath. Starts/aborts matches, clears both
//  per-player score calculators, holds the ball for a serve delay, releases it for the rally,

---
 rtl/pong_pkg.sv | 13 +
 rtl/pulse_rise_detect.sv | 17 +
 rtl/pong_match_controller.sv | 135 +++++++++++++
 tb/tb_pong_match_controller.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types for the pong datapath: match phases and score width.
package pong_pkg;
  localparam int SCORE_W = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CLEAR      = 3'd1,
    SERVE_WAIT = 3'd2,
    RALLY      = 3'd3,
    POINT      = 3'd4,
    GAME_OVER  = 3'd5
  } match_state_e;
endpackage

// File: rtl/pulse_rise_detect.sv
// Rising-edge detector: one history flop, rise is combinational on the live input.
module pulse_rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise
);
  logic sig_q, sig_d;

  assign sig_d = sig_in;
  assign rise  = sig_in & ~sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig_d;
  end
endmodule

// File: rtl/pong_match_controller.sv
// Match sequencer: start/abort, score clear, serve delay, rally, point detection, winner.
module pong_match_controller
  import pong_pkg::*;
#(
  parameter int WIN_SCORE          = 5,
  parameter int SERVE_DELAY_FRAMES = 60
) (
  input  logic               clk_25MHz,
  input  logic               reset_n,
  input  logic               start_btn,
  input  logic               frame_tick,
  input  logic [SCORE_W-1:0] score_left,
  input  logic [SCORE_W-1:0] score_right,
  output logic               clear_scores,
  output logic               ball_reset,
  output logic               ball_run,
  output logic               serve_left,
  output logic               game_over,
  output logic               winner,
  output logic [2:0]         phase
);
  localparam int                 CNT_W    = $clog2(SERVE_DELAY_FRAMES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_DELAY_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);

  match_state_e       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] lat_left_q, lat_left_d;
  logic [SCORE_W-1:0] lat_right_q, lat_right_d;
  logic               serve_left_q, serve_left_d;
  logic               winner_q, winner_d;
  logic               start_rise;
  logic               score_chg, new_win, lat_win;

  pulse_rise_detect u_start_edge (
    .clk    (clk_25MHz),
    .rst_n  (reset_n),
    .sig_in (start_btn),
    .rise   (start_rise)
  );

  assign score_chg = (score_left != lat_left_q) || (score_right != lat_right_q);
  assign new_win   = (score_left >= WIN_VAL) || (score_right >= WIN_VAL);
  assign lat_win   = (lat_left_q >= WIN_VAL) || (lat_right_q >= WIN_VAL);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lat_left_d   = lat_left_q;
    lat_right_d  = lat_right_q;
    serve_left_d = serve_left_q;
    winner_d     = winner_q;
    clear_scores = 1'b0;
    ball_reset   = 1'b0;
    ball_run     = 1'b0;
    game_over    = 1'b0;

    case (state_q)
      IDLE: if (start_rise) state_d = CLEAR;
      CLEAR: begin
        clear_scores = 1'b1;
        ball_reset   = 1'b1;
        lat_left_d   = '0;
        lat_right_d  = '0;
        cnt_d        = '0;
        serve_left_d = 1'b0;
        winner_d     = 1'b0;
        state_d      = SERVE_WAIT;
      end
      SERVE_WAIT: begin
        if (frame_tick) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = RALLY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      RALLY: begin
        ball_run = 1'b1;
        if (score_chg) begin
          lat_left_d  = score_left;
          lat_right_d = score_right;
          state_d     = POINT;
          // Right credited last, so a double point serves toward the left player.
          if (!new_win) serve_left_d = (score_right != lat_right_q);
        end
      end
      POINT: begin
        if (lat_win) begin
          winner_d = ~(lat_left_q >= WIN_VAL);
          state_d  = GAME_OVER;
        end else begin
          ball_reset = 1'b1;
          state_d    = SERVE_WAIT;
        end
      end
      GAME_OVER: begin
        game_over = 1'b1;
        if (start_rise) state_d = CLEAR;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything; drop POINT's ball_reset so it never abuts CLEAR's.
    if (start_rise && (state_q inside {SERVE_WAIT, RALLY, POINT})) begin
      state_d    = CLEAR;
      cnt_d      = '0;
      ball_reset = 1'b0;
    end
  end

  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lat_left_q   <= '0;
      lat_right_q  <= '0;
      serve_left_q <= 1'b0;
      winner_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lat_left_q   <= lat_left_d;
      lat_right_q  <= lat_right_d;
      serve_left_q <= serve_left_d;
      winner_q     <= winner_d;
    end
  end

  assign serve_left = serve_left_q;
  assign winner     = winner_q;
  assign phase      = state_q;
endmodule

// File: tb/tb_pong_match_controller.sv
// Randomized bench for pong_match_controller against a points-and-rules referee model.
module tb_pong_match_controller;
  localparam int WIN = 3;
  localparam int SD  = 3;
  localparam logic [2:0] P_IDLE = 3'd0, P_CLEAR = 3'd1, P_SW = 3'd2,
                         P_RALLY = 3'd3, P_POINT = 3'd4, P_GO = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n, start_btn, frame_tick;
  logic [7:0] score_l, score_r;
  logic       clear_scores, ball_reset, ball_run, serve_left, game_over, winner;
  logic [2:0] phase;

  int tests = 0;
  int fails = 0;
  int ref_l, ref_r;

  typedef struct {
    int         drops;
    logic       run1, rst1, srv1;
    logic [2:0] ph1, ph2;
    logic       go2, win2, rst2;
  } pt_obs_t;

  always #20 clk = ~clk;

  pong_match_controller #(.WIN_SCORE(WIN), .SERVE_DELAY_FRAMES(SD)) dut (
    .clk_25MHz(clk), .reset_n(rst_n), .start_btn(start_btn), .frame_tick(frame_tick),
    .score_left(score_l), .score_right(score_r), .clear_scores(clear_scores),
    .ball_reset(ball_reset), .ball_run(ball_run), .serve_left(serve_left),
    .game_over(game_over), .winner(winner), .phase(phase)
  );

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic press_start(output logic [2:0] ph, output logic cs, br, go, cs2, br2);
    start_btn = 1'b1; cyc();
    ph = phase; cs = clear_scores; br = ball_reset; go = game_over;
    start_btn = 1'b0; ref_l = 0; ref_r = 0; score_l = 8'd0; score_r = 8'd0;
    cyc();
    cs2 = clear_scores; br2 = ball_reset;
  endtask

  task automatic release_ball(output int early, output logic run_after, output logic [2:0] ph_after);
    early = 0;
    for (int t = 0; t < SD; t++) begin
      repeat ($urandom_range(0, 4)) begin
        cyc();
        if (ball_run !== 1'b0) early++;
      end
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
      if (t < SD - 1 && ball_run !== 1'b0) early++;
    end
    run_after = ball_run; ph_after = phase;
  endtask

  task automatic do_point(input bit l, input bit r, output pt_obs_t o);
    o.drops = 0;
    repeat ($urandom_range(0, 5)) begin
      cyc();
      if (ball_run !== 1'b1) o.drops++;
    end
    ref_l += int'(l); ref_r += int'(r);
    score_l = 8'(ref_l); score_r = 8'(ref_r);
    cyc();
    o.run1 = ball_run; o.rst1 = ball_reset; o.srv1 = serve_left; o.ph1 = phase;
    cyc();
    o.ph2 = phase; o.go2 = game_over; o.win2 = winner; o.rst2 = ball_reset;
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0; start_btn = 1'b0; frame_tick = 1'b0; score_l = 8'd0; score_r = 8'd0;
    repeat (3) cyc();
    tests++;
    if ({phase, clear_scores, ball_reset, ball_run, serve_left, game_over, winner} !== 9'd0) begin
      fails++;
      $display("FAIL reset_state: got phase=%0d outs=%b required phase=0 outs=000000", phase,
               {clear_scores, ball_reset, ball_run, serve_left, game_over, winner});
    end
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      cyc();
      if (phase !== P_IDLE || ball_run !== 1'b0 || clear_scores !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL idle_hold: %0d non-idle cycles, required 0", bad);
    end
  endtask

  task automatic test_start();
    logic [2:0] ph, pha; logic cs, br, go, cs2, br2, run; int early;
    press_start(ph, cs, br, go, cs2, br2);
    tests++;
    if (ph !== P_CLEAR || cs !== 1'b1 || br !== 1'b1 || go !== 1'b0) begin
      fails++;
      $display("FAIL start_pulse: got ph=%0d cs=%b br=%b go=%b required 1 1 1 0", ph, cs, br, go);
    end
    tests++;
    if (cs2 !== 1'b0 || br2 !== 1'b0) begin
      fails++;
      $display("FAIL start_pulse_width: got cs=%b br=%b second cycle, required 0 0", cs2, br2);
    end
    release_ball(early, run, pha);
    tests++;
    if (early != 0 || run !== 1'b1 || pha !== P_RALLY) begin
      fails++;
      $display("FAIL serve_release: early=%0d run=%b ph=%0d required 0 1 3", early, run, pha);
    end
  endtask

  // Plays whole matches; the first match follows a fixed point script, the rest are random.
  task automatic test_random_matches();
    logic [2:0] ph, pha; logic cs, br, go, cs2, br2, run; int early, bad;
    pt_obs_t o; bit l, r, win; int sel, pidx;
    for (int m = 0; m < 5; m++) begin
      if (m > 0) begin
        press_start(ph, cs, br, go, cs2, br2);
        tests++;
        if (ph !== P_CLEAR || cs !== 1'b1 || go !== 1'b0 || cs2 !== 1'b0) begin
          fails++;
          $display("FAIL restart: got ph=%0d cs=%b go=%b cs2=%b required 1 1 0 0", ph, cs, go, cs2);
        end
        release_ball(early, run, pha);
        tests++;
        if (early != 0 || run !== 1'b1) begin
          fails++;
          $display("FAIL release_m%0d: early=%0d run=%b required 0 1", m, early, run);
        end
      end
      pidx = 0;
      win = 1'b0;
      while (!win) begin
        if (m == 0) begin
          l = (pidx == 0); r = (pidx != 0);
        end else begin
          sel = int'($urandom_range(0, 9));
          l = (sel < 4) || (sel >= 8); r = (sel >= 4);
        end
        pidx++;
        do_point(l, r, o);
        win = (ref_l >= WIN) || (ref_r >= WIN);
        tests++;
        if (o.drops != 0 || o.ph1 !== P_POINT || o.run1 !== 1'b0 || o.rst1 !== !win) begin
          fails++;
          $display("FAIL point_m%0d_%0d: drops=%0d ph=%0d run=%b rst=%b required 0 4 0 %b",
                   m, pidx, o.drops, o.ph1, o.run1, o.rst1, !win);
        end
        if (!win) begin
          tests++;
          if (o.srv1 !== r || o.ph2 !== P_SW || o.rst2 !== 1'b0 || o.go2 !== 1'b0) begin
            fails++;
            $display("FAIL reserve_m%0d_%0d: srv=%b ph=%0d rst=%b go=%b required %b 2 0 0",
                     m, pidx, o.srv1, o.ph2, o.rst2, o.go2, r);
          end
          release_ball(early, run, pha);
          tests++;
          if (early != 0 || run !== 1'b1 || pha !== P_RALLY) begin
            fails++;
            $display("FAIL rerelease_m%0d_%0d: early=%0d run=%b ph=%0d required 0 1 3",
                     m, pidx, early, run, pha);
          end
        end else begin
          tests++;
          if (o.ph2 !== P_GO || o.go2 !== 1'b1 || o.win2 !== (ref_l >= WIN ? 1'b0 : 1'b1)) begin
            fails++;
            $display("FAIL winner_m%0d: ph=%0d go=%b win=%b required 5 1 %b (score %0d-%0d)",
                     m, o.ph2, o.go2, o.win2, (ref_l >= WIN ? 1'b0 : 1'b1), ref_l, ref_r);
          end
        end
      end
      bad = 0;
      repeat (10) begin
        cyc();
        if (game_over !== 1'b1 || ball_run !== 1'b0 || phase !== P_GO) bad++;
      end
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL game_over_hold_m%0d: %0d bad cycles, required 0", m, bad);
      end
    end
  endtask

  task automatic test_tie();
    logic [2:0] ph, pha; logic cs, br, go, cs2, br2, run; int early; pt_obs_t o;
    press_start(ph, cs, br, go, cs2, br2);
    release_ball(early, run, pha);
    for (int i = 0; i < 4; i++) begin
      do_point(i % 2 == 0, i % 2 == 1, o);
      release_ball(early, run, pha);
    end
    do_point(1'b1, 1'b1, o);
    tests++;
    if (o.go2 !== 1'b1 || o.win2 !== 1'b0 || o.ph2 !== P_GO) begin
      fails++;
      $display("FAIL tie_break: go=%b win=%b ph=%0d required 1 0 5", o.go2, o.win2, o.ph2);
    end
  endtask

  task automatic test_ignore_scores();
    logic [2:0] ph, pha; logic cs, br, go, cs2, br2, run; int early, bad;
    press_start(ph, cs, br, go, cs2, br2);
    score_l = 8'(1 + $urandom_range(0, 9)); score_r = 8'(1 + $urandom_range(0, 9));
    bad = 0;
    repeat (6) begin
      cyc();
      if (phase !== P_SW || ball_run !== 1'b0) bad++;
    end
    score_l = 8'd0; score_r = 8'd0;
    release_ball(early, run, pha);
    repeat (5) begin
      cyc();
      if (phase !== P_RALLY) bad++;
    end
    tests++;
    if (bad != 0 || run !== 1'b1) begin
      fails++;
      $display("FAIL ignore_scores: %0d bad cycles run=%b, required 0 1", bad, run);
    end
  endtask

  task automatic test_abort();
    logic [2:0] ph, pha; logic cs, br, go, cs2, br2, run; int early;
    // Abort in RALLY.
    start_btn = 1'b1; cyc();
    tests++;
    if (phase !== P_CLEAR || clear_scores !== 1'b1 || ball_run !== 1'b0) begin
      fails++;
      $display("FAIL abort_rally: ph=%0d cs=%b run=%b required 1 1 0", phase, clear_scores, ball_run);
    end
    start_btn = 1'b0; ref_l = 0; ref_r = 0; score_l = 8'd0; score_r = 8'd0;
    cyc();
    // Abort in SERVE_WAIT after one tick; the full delay must restart.
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
    press_start(ph, cs, br, go, cs2, br2);
    tests++;
    if (ph !== P_CLEAR || cs !== 1'b1) begin
      fails++;
      $display("FAIL abort_serve: ph=%0d cs=%b required 1 1", ph, cs);
    end
    release_ball(early, run, pha);
    tests++;
    if (early != 0 || run !== 1'b1) begin
      fails++;
      $display("FAIL abort_counter: early=%0d run=%b required 0 1", early, run);
    end
  endtask

  task automatic test_async_reset();
    cyc();
    #10 rst_n = 1'b0;
    #1;
    tests++;
    if (ball_run !== 1'b0 || phase !== P_IDLE) begin
      fails++;
      $display("FAIL async_reset: run=%b ph=%0d required 0 0", ball_run, phase);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) cyc();
    tests++;
    if (phase !== P_IDLE || ball_run !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_idle: ph=%0d run=%b required 0 0", phase, ball_run);
    end
  endtask

  initial begin
    ref_l = 0; ref_r = 0;
    test_reset();
    test_start();
    test_random_matches();
    test_tie();
    test_ignore_scores();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
